region_guard_n: RTL

REGION_GUARD_N -- requirements
Module: region_guard_n

---
 rtl/region_guard_n.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/region_guard_n.sv
// Guard for protected code regions and a key memory window.
// Any access-rule violation forces a held system reset request.
module region_guard_n #(
    parameter int                 NREG          = 2,
    parameter logic [16*NREG-1:0] REG_BASE      = {16'hE100, 16'hA000},
    parameter logic [16*NREG-1:0] REG_SIZE      = {16'h0FFF, 16'h4000},
    parameter logic [15:0]        KMEM_BASE     = 16'h6A00,
    parameter logic [15:0]        KMEM_SIZE     = 16'h001F,
    parameter logic [15:0]        RESET_HANDLER = 16'h0000,
    parameter int                 HOLD_CYCLES   = 4,
    parameter int                 CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      pc,
    input  logic             data_en,
    input  logic             data_wr,
    input  logic [15:0]      data_addr,
    input  logic             dma_en,
    input  logic [15:0]      dma_addr,
    input  logic             irq,
    output logic             viol_reset,
    output logic [2:0]       viol_cause,
    output logic [1:0]       viol_region,
    output logic [CNT_W-1:0] viol_count,
    output logic [NREG-1:0]  in_region
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [15:0] KMEM_LAST = KMEM_BASE + KMEM_SIZE;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_KILL = 1'b1;

    logic [0:0]       r_state;
    logic [HW-1:0]    r_hold;
    logic [15:0]      r_prev_pc;
    logic [NREG-1:0]  r_in;
    logic [2:0]       r_cause;
    logic [1:0]       r_region;
    logic [CNT_W-1:0] r_count;

    logic [15:0]      w_lo [NREG];
    logic [15:0]      w_hi [NREG];
    logic [NREG-1:0]  w_pc_in;
    logic [NREG-1:0]  w_wa_in;
    logic [NREG-1:0]  w_ill_ent;
    logic [NREG-1:0]  w_ill_ext;
    logic             w_any_in;
    logic             w_kmem_d;
    logic             w_kmem_dma;
    logic [7:1]       w_c;
    logic             w_viol;
    logic [2:0]       w_cause;
    logic [1:0]       w_region;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        assign w_lo[g]      = REG_BASE[16*g +: 16];
        assign w_hi[g]      = w_lo[g] + REG_SIZE[16*g +: 16];
        assign w_pc_in[g]   = (pc >= w_lo[g]) && (pc <= w_hi[g]);
        assign w_wa_in[g]   = (data_addr >= w_lo[g]) && (data_addr <= w_hi[g]);
        assign w_ill_ent[g] = !r_in[g] && w_pc_in[g] && (pc != w_lo[g]);
        // Leaving is legal only straight after executing the last address
        assign w_ill_ext[g] = r_in[g] && !w_pc_in[g] && (r_prev_pc != w_hi[g]);
    end

    assign w_any_in   = |r_in;
    assign w_kmem_d   = (data_addr >= KMEM_BASE) && (data_addr <= KMEM_LAST);
    assign w_kmem_dma = (dma_addr >= KMEM_BASE) && (dma_addr <= KMEM_LAST);

    assign w_c[1] = |w_ill_ent;
    assign w_c[2] = |w_ill_ext;
    assign w_c[3] = irq && w_any_in;
    assign w_c[4] = dma_en && w_any_in;
    assign w_c[5] = data_en && w_kmem_d && !r_in[0];
    assign w_c[6] = dma_en && w_kmem_dma;
    assign w_c[7] = data_en && data_wr && (|w_wa_in);
    assign w_viol = |w_c;

    function automatic logic [1:0] f_low(input logic [NREG-1:0] v);
        logic [1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    always_comb begin
        w_cause  = 3'd0;
        w_region = 2'd0;
        if (w_c[1]) begin
            w_cause  = 3'd1;
            w_region = f_low(w_ill_ent);
        end else if (w_c[2]) begin
            w_cause  = 3'd2;
            w_region = f_low(w_ill_ext);
        end else if (w_c[3]) begin
            w_cause  = 3'd3;
            w_region = f_low(r_in);
        end else if (w_c[4]) begin
            w_cause  = 3'd4;
            w_region = f_low(r_in);
        end else if (w_c[5]) begin
            w_cause  = 3'd5;
        end else if (w_c[6]) begin
            w_cause  = 3'd6;
        end else if (w_c[7]) begin
            w_cause  = 3'd7;
            w_region = f_low(w_wa_in);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_hold    <= '0;
            r_prev_pc <= '0;
            r_in      <= '0;
            r_cause   <= '0;
            r_region  <= '0;
            r_count   <= '0;
        end else begin
            r_prev_pc <= pc;
            if (r_state == ST_RUN) begin
                if (w_viol) begin
                    r_state  <= ST_KILL;
                    r_hold   <= HOLD_LOAD;
                    r_cause  <= w_cause;
                    r_region <= w_region;
                    r_in     <= '0;
                    if (r_count != '1) r_count <= r_count + 1'b1;
                end else begin
                    for (int i = 0; i < NREG; i++) begin
                        if (!r_in[i] && pc == w_lo[i]) r_in[i] <= 1'b1;
                        else if (r_in[i] && !w_pc_in[i]) r_in[i] <= 1'b0;
                    end
                end
            end else begin
                r_in <= '0;
                if (r_hold != '0) r_hold <= r_hold - 1'b1;
                else if (pc == RESET_HANDLER) r_state <= ST_RUN;
            end
        end
    end

    assign viol_reset  = (r_state == ST_KILL);
    assign viol_cause  = r_cause;
    assign viol_region = r_region;
    assign viol_count  = r_count;
    assign in_region   = r_in;

endmodule
